// File: rtl/mt9v034_i2c_master.sv
// rtl/mt9v034_i2c_master.sv - I2C register master for the MT9V034 serial interface
// Runs 16-bit register writes/reads on open-drain pad enables, paced by a quarter-period tick.
module mt9v034_i2c_master #(
  parameter int         CLK_DIV  = 120,
  parameter logic [6:0] DEV_ADDR = 7'h5C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] rd_data,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SEND_BYTE, S_GET_ACK, S_RESTART,
    S_RECV_BYTE, S_PUT_ACK, S_STOP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic        rw_q, rw_d;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rx_hi_q, rx_hi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;

  logic        run, tick, pull_sda;
  logic [7:0]  tx_byte;

  // Returns {scl_oe, sda_oe} for a phase quarter; pull is the SDA drive of bit phases.
  function automatic logic [1:0] bus_lines(input state_t st, input logic [1:0] qtr, input logic pull);
    logic [1:0] l;
    l = 2'b00;
    case (st)
      S_START:   l = (qtr == 2'd2) ? 2'b01 : (qtr == 2'd3) ? 2'b11 : 2'b00;
      S_RESTART: l = (qtr == 2'd0) ? 2'b10 : (qtr == 2'd1) ? 2'b00 : (qtr == 2'd2) ? 2'b01 : 2'b11;
      S_SEND_BYTE, S_GET_ACK, S_RECV_BYTE, S_PUT_ACK:
                 l = {(qtr == 2'd0) || (qtr == 2'd3), pull};
      S_STOP:    l = (qtr == 2'd0) ? 2'b11 : (qtr == 2'd3) ? 2'b00 : 2'b01;
      default:   l = 2'b00;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rw_d      = rw_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rx_hi_d   = rx_hi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;

    run   = busy_q && (state_q != S_DONE);
    tick  = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d = (run && !tick) ? cnt_q + CW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d      = rw;
          reg_d     = reg_addr;
          wdata_d   = wr_data;
          ack_err_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_START;
          qtr_d     = 2'd0;
          bit_d     = 3'd0;
          byte_d    = 3'd0;
        end
      end
      S_DONE: begin
        if (rw_q && !ack_err_q) rd_data_d = {rx_hi_q, rx_q};
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        if (run && tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            if (state_q == S_GET_ACK && sda_i) ack_err_d = 1'b1;
            if (state_q == S_RECV_BYTE) rx_d = {rx_q[6:0], sda_i};
          end
          if (qtr_q == 2'd3) begin
            case (state_q)
              S_START, S_RESTART: state_d = S_SEND_BYTE;
              S_SEND_BYTE: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_GET_ACK;
              end
              S_RECV_BYTE: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_PUT_ACK;
              end
              S_GET_ACK: begin
                byte_d = byte_q + 3'd1;
                if (ack_err_q)                    state_d = S_STOP;
                else if (!rw_q && byte_q == 3'd3) state_d = S_STOP;
                else if (rw_q && byte_q == 3'd1)  state_d = S_RESTART;
                else if (rw_q && byte_q == 3'd2)  state_d = S_RECV_BYTE;
                else                              state_d = S_SEND_BYTE;
              end
              S_PUT_ACK: begin
                byte_d = byte_q + 3'd1;
                if (byte_q == 3'd3) begin
                  rx_hi_d = rx_q;
                  state_d = S_RECV_BYTE;
                end else begin
                  state_d = S_STOP;
                end
              end
              S_STOP: begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase

    // Byte 2 is the read address after a restart, otherwise the high write byte.
    case (byte_d)
      3'd0:    tx_byte = {DEV_ADDR, 1'b0};
      3'd1:    tx_byte = reg_q;
      3'd2:    tx_byte = rw_q ? {DEV_ADDR, 1'b1} : wdata_q[15:8];
      default: tx_byte = wdata_q[7:0];
    endcase

    case (state_d)
      S_SEND_BYTE: pull_sda = ~tx_byte[3'd7 - bit_d];
      S_PUT_ACK:   pull_sda = (byte_d == 3'd3);
      default:     pull_sda = 1'b0;
    endcase

    {scl_oe_d, sda_oe_d} = bus_lines(state_d, qtr_d, pull_sda);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 3'd0;
      rw_q      <= 1'b0;
      reg_q     <= 8'h00;
      wdata_q   <= 16'h0000;
      rx_q      <= 8'h00;
      rx_hi_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 16'h0000;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      rw_q      <= rw_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rx_hi_q   <= rx_hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_mt9v034_i2c_master.sv
// tb/tb_mt9v034_i2c_master.sv - directed bench for mt9v034_i2c_master with a behavioural slave
// The slave decodes START/STOP and bytes from the open-drain lines, ACKs and returns read data.
module tb_mt9v034_i2c_master;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rw_i = 1'b0;
  logic [7:0]  addr_i = 8'h00;
  logic [15:0] data_i = 16'h0000;
  logic        busy, done, ack_err, scl_oe, sda_oe;
  logic [15:0] rd_data;
  logic        slave_pull = 1'b0;
  logic        sda_w, scl_w;

  assign scl_w = ~scl_oe;
  assign sda_w = ~(sda_oe | slave_pull);

  mt9v034_i2c_master #(.CLK_DIV(DIV), .DEV_ADDR(7'h5C)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw_i), .reg_addr(addr_i),
    .wr_data(data_i), .busy(busy), .done(done), .ack_err(ack_err),
    .rd_data(rd_data), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_w)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model state
  logic        model_clr = 1'b1;
  int          nack_at = -1;
  logic [15:0] rd_val = 16'h0000;
  logic [7:0]  rx_log[$];
  logic        mack[$];
  int          n_start, n_stop, bitn, tx_cnt, done_cnt = 0;
  logic        prev_scl, prev_sda, tx_mode, first_byte, addr_rd;
  logic [7:0]  sh, tx_sr;

  always @(posedge clk) if (done) done_cnt++;

  always @(posedge clk) begin
    logic cs, cd, ackb;
    cs = scl_w;
    cd = sda_w;
    if (model_clr) begin
      rx_log.delete();
      mack.delete();
      n_start = 0; n_stop = 0; bitn = 0; tx_cnt = 0;
      tx_mode = 0; first_byte = 0; addr_rd = 0; sh = 0; tx_sr = 0;
      slave_pull <= 1'b0;
    end else if (prev_scl && cs && prev_sda && !cd) begin
      n_start++; bitn = 0; tx_mode = 0; first_byte = 1;
      slave_pull <= 1'b0;
    end else if (prev_scl && cs && !prev_sda && cd) begin
      n_stop++; bitn = 0; tx_mode = 0;
      slave_pull <= 1'b0;
    end else if (!prev_scl && cs) begin
      if (bitn < 8) begin
        if (!tx_mode) sh = {sh[6:0], cd};
      end else if (tx_mode) begin
        mack.push_back(cd);
      end
      bitn++;
    end else if (prev_scl && !cs) begin
      if (bitn == 8) begin
        if (!tx_mode) begin
          rx_log.push_back(sh);
          ackb = (rx_log.size() - 1 != nack_at);
          addr_rd = first_byte && sh[0] && ackb;
          first_byte = 0;
          slave_pull <= ackb;
        end else begin
          slave_pull <= 1'b0;
        end
      end else if (bitn == 9) begin
        bitn = 0;
        slave_pull <= 1'b0;
        if (addr_rd) begin
          addr_rd = 0; tx_mode = 1; tx_cnt = 0; tx_sr = rd_val[15:8];
          slave_pull <= ~tx_sr[7];
        end else if (tx_mode && mack.size() > 0 && mack[$] == 1'b0 && tx_cnt == 0) begin
          tx_cnt = 1; tx_sr = rd_val[7:0];
          slave_pull <= ~tx_sr[7];
        end else begin
          tx_mode = 0;
        end
      end else if (bitn >= 1 && bitn <= 7 && tx_mode) begin
        slave_pull <= ~tx_sr[7 - bitn];
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  task automatic clr_model();
    @(negedge clk);
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  // Pulses start for one cycle; returns at the negedge after acceptance.
  task automatic launch(input logic r, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; rw_i = r; addr_i = a; data_i = d;
    @(negedge clk);
    start = 1'b0; rw_i = ~r; addr_i = 8'h55; data_i = 16'hFFFF;
  endtask

  task automatic wait_done(input int poke, output int lat);
    lat = 0;
    while (!done && lat < 4000) begin
      start = (lat == poke);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  function automatic int win(input int lat, input int exp);
    return (lat >= exp - 2 && lat <= exp + 2) ? exp : lat;
  endfunction

  int lat;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clr = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);

    // Write 0x0D <- 0x0300, with an ignored start to 0x55 mid-transfer
    clr_model();
    launch(1'b0, 8'h0D, 16'h0300);
    check("wr_busy", busy, 1);
    wait_done(300, lat);
    check("wr_lat", win(lat, 152 * DIV), 152 * DIV);
    check("wr_ack_err", ack_err, 0);
    check("wr_nbytes", rx_log.size(), 4);
    check("wr_b0", rx_log[0], 8'hB8);
    check("wr_b1", rx_log[1], 8'h0D);
    check("wr_b2", rx_log[2], 8'h03);
    check("wr_b3", rx_log[3], 8'h00);
    check("wr_starts", n_start, 1);
    check("wr_stops", n_stop, 1);
    check("wr_rd_data", rd_data, 0);
    @(negedge clk);
    check("wr_done_pulse", done, 0);
    check("wr_idle_lines", {scl_oe, sda_oe}, 2'b00);
    repeat (20) @(negedge clk);
    check("wr_no_second", busy, 0);

    // Read 0x00, slave returns chip ID 0x1324
    clr_model();
    rd_val = 16'h1324;
    launch(1'b1, 8'h00, 16'h0000);
    wait_done(-1, lat);
    check("rd_lat", win(lat, 192 * DIV), 192 * DIV);
    check("rd_nbytes", rx_log.size(), 3);
    check("rd_b0", rx_log[0], 8'hB8);
    check("rd_b1", rx_log[1], 8'h00);
    check("rd_b2", rx_log[2], 8'hB9);
    check("rd_starts", n_start, 2);
    check("rd_stops", n_stop, 1);
    check("rd_nmack", mack.size(), 2);
    check("rd_mack0", mack[0], 1'b0);
    check("rd_mack1", mack[1], 1'b1);
    check("rd_ack_err", ack_err, 0);
    @(negedge clk);
    check("rd_data", rd_data, 16'h1324);

    // Address NACK during a read
    clr_model();
    nack_at = 0;
    rd_val = 16'hBEEF;
    launch(1'b1, 8'h00, 16'h0000);
    wait_done(-1, lat);
    check("nk_lat", win(lat, 44 * DIV), 44 * DIV);
    check("nk_ack_err", ack_err, 1);
    check("nk_nbytes", rx_log.size(), 1);
    check("nk_stops", n_stop, 1);
    @(negedge clk);
    check("nk_rd_kept", rd_data, 16'h1324);
    check("nk_err_sticky", ack_err, 1);

    // Write then read with start asserted in the done cycle
    clr_model();
    nack_at = -1;
    rd_val = 16'h5A3C;
    launch(1'b0, 8'h10, 16'h1234);
    check("b2b_err_clr", ack_err, 0);
    wait_done(-1, lat);
    check("b2b_wr_lat", win(lat, 152 * DIV), 152 * DIV);
    start = 1'b1; rw_i = 1'b1; addr_i = 8'h00; data_i = 16'h0000;
    @(negedge clk);
    check("b2b_gap_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; rw_i = 1'b0;
    check("b2b_rd_busy", busy, 1);
    wait_done(-1, lat);
    check("b2b_rd_lat", win(lat, 192 * DIV), 192 * DIV);
    check("b2b_wbytes", {rx_log[1], rx_log[2], rx_log[3]}, 24'h101234);
    @(negedge clk);
    check("b2b_rd_data", rd_data, 16'h5A3C);

    // Reset at quarter 70 of a read: last reg-address bit (0) is on SDA
    clr_model();
    launch(1'b1, 8'h00, 16'h0000);
    repeat (70 * DIV + DIV / 2) @(negedge clk);
    check("pre_rst_sda", sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_scl", scl_oe, 0);
    check("mid_rst_sda", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd", rd_data, 0);
    lat = done_cnt;
    repeat (300) @(negedge clk);
    check("mid_rst_nodone", done_cnt, lat);
    check("mid_rst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
